// File: rtl/change_dispenser.sv
// Greedy change dispenser: accepts a refund amount and emits coins largest-first
// on a valid/ack handshake. Optional CHANGE_STATS_EN builds the total_paid accumulator.
module change_dispenser (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [7:0]  req_amount,
  output logic        busy,
  output logic        coin_valid,
  output logic [1:0]  coin_type,
  input  logic        coin_ack,
  output logic        done,
  output logic        shortfall,
  output logic [7:0]  remaining,
  input  logic        stock_load,
  input  logic [1:0]  stock_sel,
  input  logic [7:0]  stock_value,
  output logic [7:0]  stock0,
  output logic [7:0]  stock1,
  output logic [7:0]  stock2,
  output logic [7:0]  stock3,
  output logic [15:0] total_paid,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {IDLE, SELECT, EMIT, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] stock [4];
  logic       found;
  logic [1:0] sel_idx;

  function automatic logic [7:0] den(input logic [1:0] idx);
    case (idx)
      2'd0:    den = 8'd10;
      2'd1:    den = 8'd5;
      2'd2:    den = 8'd2;
      default: den = 8'd1;
    endcase
  endfunction

  // Descending scan so the lowest usable index (largest coin) wins.
  always_comb begin
    found   = 1'b0;
    sel_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (den(2'(i)) <= remaining && stock[i] != 8'd0) begin
        found   = 1'b1;
        sel_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = SELECT;
      SELECT:  state_next = found ? EMIT : DONE;
      EMIT:    if (coin_ack) state_next = SELECT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Handshake: a coin is consumed on any edge where coin_valid and coin_ack are
  // both high; coin_type holds steady from SELECT until that edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining <= 8'd0;
      shortfall <= 1'b0;
      coin_type <= 2'd0;
      for (int i = 0; i < 4; i++) stock[i] <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            remaining <= req_amount;
            shortfall <= 1'b0;
          end else if (stock_load) begin
            stock[stock_sel] <= stock_value;
          end
        end
        SELECT: begin
          if (found) coin_type <= sel_idx;
          else       shortfall <= (remaining != 8'd0);
        end
        EMIT: begin
          if (coin_ack) begin
            stock[coin_type] <= stock[coin_type] - 8'd1;
            remaining        <= remaining - den(coin_type);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CHANGE_STATS_EN
  logic [15:0] total_q;
  always_ff @(posedge clock) begin
    if (reset)                          total_q <= 16'd0;
    else if (state == EMIT && coin_ack) total_q <= total_q + {8'd0, den(coin_type)};
  end
  assign total_paid = total_q;
`else
  assign total_paid = 16'd0;
`endif

  assign busy       = (state != IDLE);
  assign coin_valid = (state == EMIT);
  assign done       = (state == DONE);
  assign fsm_state  = state;
  assign stock0     = stock[0];
  assign stock1     = stock[1];
  assign stock2     = stock[2];
  assign stock3     = stock[3];

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: directed requests push expected coins and
// done records; a monitor pops and compares as the DUT presents them.
module tb_change_dispenser;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid = 1'b0;
  logic [7:0]  req_amount = 8'd0;
  logic        busy, coin_valid, coin_ack, done, shortfall;
  logic [1:0]  coin_type, fsm_state;
  logic [7:0]  remaining, stock0, stock1, stock2, stock3;
  logic        stock_load = 1'b0;
  logic [1:0]  stock_sel = 2'd0;
  logic [7:0]  stock_value = 8'd0;
  logic [15:0] total_paid;

  logic [1:0]  exp_coin_q[$];
  logic [8:0]  exp_done_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          done_cnt = 0;
  int          valid_cycles = 0;
  logic        ack_en = 1'b1;
  int          exp_total = 0;

  change_dispenser dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .busy(busy), .coin_valid(coin_valid), .coin_type(coin_type), .coin_ack(coin_ack),
    .done(done), .shortfall(shortfall), .remaining(remaining),
    .stock_load(stock_load), .stock_sel(stock_sel), .stock_value(stock_value),
    .stock0(stock0), .stock1(stock1), .stock2(stock2), .stock3(stock3),
    .total_paid(total_paid), .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ejector model: acks whatever is presented while ack_en is high.
  initial begin
    coin_ack = 1'b0;
    forever begin
      @(negedge clock);
      coin_ack = ack_en && coin_valid;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (coin_valid) valid_cycles++;
      if (coin_valid && coin_ack) begin
        if (exp_coin_q.size() == 0) check("unexpected_coin", 32'(coin_type), 32'hFFFF);
        else check("coin_type", 32'(coin_type), 32'(exp_coin_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else check("done_short_rem", 32'({shortfall, remaining}), 32'(exp_done_q.pop_front()));
      end
    end
  end

  task automatic load(input logic [1:0] sel, input logic [7:0] val);
    @(negedge clock);
    stock_load = 1'b1; stock_sel = sel; stock_value = val;
    @(negedge clock);
    stock_load = 1'b0;
  endtask

  task automatic request(input logic [7:0] amt);
    @(negedge clock);
    req_valid = 1'b1; req_amount = amt;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt);
    int n = 0;
    while (done_cnt == start_cnt && n < 200) begin
      @(negedge clock); #3;
      n++;
    end
    check("done_timeout", 32'(done_cnt != start_cnt), 32'd1);
  endtask

  task automatic check_stock(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
    check({tag, "_stock0"}, 32'(stock0), 32'(s0));
    check({tag, "_stock1"}, 32'(stock1), 32'(s1));
    check({tag, "_stock2"}, 32'(stock2), 32'(s2));
    check({tag, "_stock3"}, 32'(stock3), 32'(s3));
  endtask

  task automatic check_total(input string tag);
`ifdef CHANGE_STATS_EN
    check({tag, "_total_paid"}, 32'(total_paid), 32'(exp_total));
`else
    check({tag, "_total_paid"}, 32'(total_paid), 32'd0);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_coin_valid"}, 32'(coin_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_shortfall"}, 32'(shortfall), 32'd0);
    check({tag, "_coin_type"}, 32'(coin_type), 32'd0);
    check({tag, "_remaining"}, 32'(remaining), 32'd0);
    check_stock(tag, 8'd0, 8'd0, 8'd0, 8'd0);
    exp_total = 0;
    check_total(tag);
  endtask

  initial begin
    int start, vc, n;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_reset_state("reset");

    // 18 from full stock: one of each coin
    for (int i = 0; i < 4; i++) load(2'(i), 8'd4);
    check_stock("load", 8'd4, 8'd4, 8'd4, 8'd4);
    exp_coin_q.push_back(2'd0); exp_coin_q.push_back(2'd1);
    exp_coin_q.push_back(2'd2); exp_coin_q.push_back(2'd3);
    exp_done_q.push_back({1'b0, 8'd0});
    start = done_cnt;
    request(8'd18);
    wait_done(start);
    exp_total += 18;
    check_stock("req18", 8'd3, 8'd3, 8'd3, 8'd3);
    check_total("req18");

    // 20 with no tens: four fives
    load(2'd0, 8'd0);
    for (int i = 1; i < 4; i++) load(2'(i), 8'd4);
    for (int i = 0; i < 4; i++) exp_coin_q.push_back(2'd1);
    exp_done_q.push_back({1'b0, 8'd0});
    start = done_cnt;
    request(8'd20);
    wait_done(start);
    exp_total += 20;
    check_stock("req20", 8'd0, 8'd0, 8'd4, 8'd4);
    check_total("req20");

    // 3 with a single one-unit coin: shortfall of 2
    load(2'd2, 8'd0);
    load(2'd3, 8'd1);
    exp_coin_q.push_back(2'd3);
    exp_done_q.push_back({1'b1, 8'd2});
    start = done_cnt;
    request(8'd3);
    wait_done(start);
    exp_total += 1;
    @(negedge clock);
    check("short_hold_shortfall", 32'(shortfall), 32'd1);
    check("short_hold_remaining", 32'(remaining), 32'd2);
    check_stock("req3", 8'd0, 8'd0, 8'd0, 8'd0);

    // zero amount: done exactly two edges after acceptance, no coins
    vc = valid_cycles;
    exp_done_q.push_back({1'b0, 8'd0});
    request(8'd0);
    check("zero_busy_n1", 32'(busy), 32'd1);
    check("zero_done_n1", 32'(done), 32'd0);
    @(negedge clock);
    check("zero_done_n2", 32'(done), 32'd1);
    @(negedge clock);
    check("zero_busy_after", 32'(busy), 32'd0);
    check("zero_no_coin", 32'(valid_cycles), 32'(vc));
    check("zero_shortfall", 32'(shortfall), 32'd0);

    // stall in EMIT for 10 cycles
    load(2'd0, 8'd2);
    ack_en = 1'b0;
    exp_coin_q.push_back(2'd0);
    exp_done_q.push_back({1'b0, 8'd0});
    start = done_cnt;
    request(8'd10);
    n = 0;
    while (!coin_valid && n < 20) begin @(negedge clock); n++; end
    check("stall_valid_seen", 32'(coin_valid), 32'd1);
    repeat (10) begin
      @(negedge clock);
      check("stall_valid", 32'(coin_valid), 32'd1);
      check("stall_type", 32'(coin_type), 32'd0);
    end
    check("stall_stock0", 32'(stock0), 32'd2);
    ack_en = 1'b1;
    wait_done(start);
    exp_total += 10;
    check("stall_stock0_after", 32'(stock0), 32'd1);
    check_total("stall");

    // stock_load while busy is ignored, then reset aborts mid-EMIT
    load(2'd3, 8'd5);
    ack_en = 1'b0;
    request(8'd1);
    n = 0;
    while (!coin_valid && n < 20) begin @(negedge clock); n++; end
    check("abort_valid_seen", 32'(coin_valid), 32'd1);
    load(2'd3, 8'd99);
    check("busy_load_ignored", 32'(stock3), 32'd5);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_state("abort");
    ack_en = 1'b1;
    repeat (3) @(negedge clock);

    check("exp_coin_q_empty", 32'(exp_coin_q.size()), 32'd0);
    check("exp_done_q_empty", 32'(exp_done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Returns money to the customer, the counterpart of the purchase path that takes customer cash into the machine. A refund or overpayment amount is accepted through a valid/busy request. The block then emits coins one at a time on a valid/ack handshake using a greedy largest-denomination-first policy. It maintains per-denomination coin stock counters and flags a shortfall when exact change cannot be completed. It sits between the purchase/cash-handling logic and the physical coin ejector.

## Interface
- DEN0, 10, value of coin type 0 (largest)
- DEN1, 5, value of coin type 1
- DEN2, 2, value of coin type 2
- DEN3, 1, value of coin type 3 (smallest)
- clock  input  1  single clock, all logic on posedge
- reset  input  1  synchronous, active-high
- req_valid  input  1  request to dispense req_amount; sampled only in IDLE
- req_amount  input  8  amount to return, in machine money units
- busy  output  1  high from the cycle after acceptance until DONE exits
- coin_valid  output  1  coin_type is presented to the ejector
- coin_type  output  2  denomination index 0..3
- coin_ack  input  1  ejector consumed the coin; meaningful only with coin_valid
- done  output  1  one-cycle pulse at end of every accepted request
- shortfall  output  1  with done: change incomplete; held until next acceptance
- remaining  output  8  amount still owed; valid while busy and after done
- stock_load  input  1  write stock_value into counter stock_sel (IDLE only)
- stock_sel  input  2  counter index for stock_load
- stock_value  input  8  new stock count
- stock0..stock3  output  8 each  current coin counts
- total_paid  output  16  cumulative value dispensed (see Configuration)

## Operation
- States: IDLE, SELECT, EMIT, DONE.
- IDLE: if req_valid is high, latch remaining <= req_amount, clear shortfall, go to SELECT. Otherwise, if stock_load is high, load the selected counter. If req_valid and stock_load are both high, the request wins and the load is dropped.
- SELECT (1 cycle): choose the lowest index i with DENi <= remaining and stocki > 0.
  - If a coin is found, go to EMIT with coin_type = i.
  - If none is found and remaining == 0, go to DONE with shortfall = 0.
  - If none is found and remaining > 0, go to DONE with shortfall = 1.
- EMIT: coin_valid = 1; coin_type is stable until ack. When coin_ack is high:
  - stock[coin_type] decrements by 1;
  - remaining decrements by DEN[coin_type];
  - go to SELECT.
  - A low coin_ack stalls indefinitely with no timeout.
- DONE: done = 1 for one cycle, then return to IDLE. remaining and shortfall hold their values.
- Arithmetic: the remaining subtraction never underflows because SELECT guarantees DEN <= remaining. Stock never underflows because stock > 0 is checked. Values loaded through stock_load are taken verbatim.
- stock_load, req_valid and coin_ack are ignored outside the states listed above.

## Timing
- Reset values: state IDLE; busy, coin_valid, done, shortfall = 0; coin_type = 0; remaining = 0; all stock = 0; total_paid = 0.
- Request accepted at edge N → busy = 1 and SELECT from N+1 → coin_valid from N+2 at the earliest.
- Ack at edge M → SELECT at M+1 → next coin_valid at M+2. Each coin therefore takes a minimum of 2 cycles.
- A zero amount, or no usable coin, gives done at N+2 with no coin_valid.
- busy deasserts in the cycle after done.
- Reset mid-operation aborts the request. No done is produced, the coin is not counted, and all counters return to 0.

## Configuration
- CHANGE_STATS_EN defined:
  - total_paid accumulates DEN[coin_type] on every acked coin;
  - it wraps modulo 2^16 and clears only on reset.
- CHANGE_STATS_EN undefined:
  - the accumulator is not built;
  - total_paid is tied to 0.

## Test plan
- Stock 4/4/4/4, req_amount 18 → coins 0,1,2,3 in order; done with shortfall 0; remaining 0; stock 3/3/3/3; total_paid 18 with the macro.
- Stock 0/4/4/4, req_amount 20 → four type-1 coins; stock1 ends at 0; shortfall 0.
- Stock 0/0/0/1, req_amount 3 → one type-3 coin, then done with shortfall 1 and remaining 2.
- req_amount 0 → done at N+2; coin_valid is never high; shortfall 0.
- coin_ack held low for 10 cycles in EMIT → coin_valid and coin_type stable, stock unchanged. Ack then advances normally.
- Reset asserted during EMIT → next cycle: IDLE, all outputs at their reset values, no done pulse. A stock_load issued while busy has no effect.
